// File: rtl/filt_pkg.sv
// Shared filter definitions: sequencer state encoding, tap index type, Q-format
// constants and the round/saturate helper used by the filter family.
package filt_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} filt_state_e;

  typedef logic [2:0] tap_t;
  localparam tap_t TAP_LAST = 3'd4;

  localparam int Q_FRAC = 14;
  localparam int Q_ONE  = 1 << Q_FRAC;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] val;
  } sat_res_t;

  // Round half up at bit 'frac', then clamp to a signed 'bits'-wide range.
  function automatic sat_res_t round_sat(input logic signed [63:0] acc,
                                         input int frac, input int bits);
    logic signed [63:0] r, hi, lo;
    sat_res_t res;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    res.sat = 1'b1;
    if (r > hi)      res.val = hi[31:0];
    else if (r < lo) res.val = lo[31:0];
    else begin
      res.val = r[31:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/iir_biquad_seq_if.sv
// Sample stream pair (in/out valid-ready) for the sequential biquad.
interface iir_biquad_seq_if #(parameter int CALC_BITS = 16);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [CALC_BITS-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [CALC_BITS-1:0] out_data;
  logic                        out_sat;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sat);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/filt_mac.sv
// Signed multiply-accumulate: acc +/- coef*data, with sync clear and enable.
module filt_mac #(
  parameter int COEF_BITS = 16,
  parameter int DATA_BITS = 16,
  parameter int ACC_BITS  = 36
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        sub,
  input  logic signed [COEF_BITS-1:0] coef,
  input  logic signed [DATA_BITS-1:0] data,
  output logic signed [ACC_BITS-1:0]  acc_nxt
);
  localparam int P_BITS = COEF_BITS + DATA_BITS;

  logic signed [P_BITS-1:0]   prod;
  logic signed [ACC_BITS-1:0] prod_ext;
  logic signed [ACC_BITS-1:0] acc;

  assign prod     = coef * data;
  assign prod_ext = {{(ACC_BITS-P_BITS){prod[P_BITS-1]}}, prod};
  assign acc_nxt  = sub ? acc - prod_ext : acc + prod_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end
endmodule

// File: rtl/iir_biquad_seq.sv
// Second-order IIR section; one MAC is stepped over the five taps per sample.
// History advances only on the output handshake so a stall never corrupts it.
module iir_biquad_seq
  import filt_pkg::*;
#(
  parameter int CALC_BITS = 16,
  parameter int COEF_BITS = 16,
  parameter int COEF_FRAC = Q_FRAC,
  parameter int ACC_BITS  = 36,
  parameter int B0        = 4096,
  parameter int B1        = 8192,
  parameter int B2        = 4096,
  parameter int A1        = -16384,
  parameter int A2        = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  iir_biquad_seq_if.slave  bus
);
  localparam logic signed [COEF_BITS-1:0] CB0 = COEF_BITS'(B0);
  localparam logic signed [COEF_BITS-1:0] CB1 = COEF_BITS'(B1);
  localparam logic signed [COEF_BITS-1:0] CB2 = COEF_BITS'(B2);
  localparam logic signed [COEF_BITS-1:0] CA1 = COEF_BITS'(A1);
  localparam logic signed [COEF_BITS-1:0] CA2 = COEF_BITS'(A2);

  filt_state_e state, state_n;
  tap_t        tap, tap_n;
  logic signed [CALC_BITS-1:0] x0, x1, x2, y1, y2, out_data_q;
  logic        out_sat_q;
  logic        accept, commit, load_out, mac_en, mac_sub;
  logic signed [COEF_BITS-1:0] mac_coef;
  logic signed [CALC_BITS-1:0] mac_data;
  logic signed [ACC_BITS-1:0]  acc_nxt;
  sat_res_t    rs;
  logic        unused_rs_hi;

  always_comb begin
    state_n  = state;
    tap_n    = tap;
    accept   = 1'b0;
    commit   = 1'b0;
    load_out = 1'b0;
    mac_en   = 1'b0;
    unique case (state)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        tap_n   = '0;
        state_n = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap == TAP_LAST) begin
          load_out = 1'b1;
          tap_n    = '0;
          state_n  = OUT;
        end else begin
          tap_n = tap + tap_t'(1);
        end
      end
      OUT: if (bus.out_ready) begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Feedback taps subtract, so the stored A coefficients keep their natural sign.
  always_comb begin
    mac_coef = CB0;
    mac_data = x0;
    mac_sub  = 1'b0;
    case (tap)
      3'd1: begin mac_coef = CB1; mac_data = x1; end
      3'd2: begin mac_coef = CB2; mac_data = x2; end
      3'd3: begin mac_coef = CA1; mac_data = y1; mac_sub = 1'b1; end
      3'd4: begin mac_coef = CA2; mac_data = y2; mac_sub = 1'b1; end
      default: ;
    endcase
  end

  filt_mac #(.COEF_BITS(COEF_BITS), .DATA_BITS(CALC_BITS), .ACC_BITS(ACC_BITS)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr | accept),
    .en      (mac_en),
    .sub     (mac_sub),
    .coef    (mac_coef),
    .data    (mac_data),
    .acc_nxt (acc_nxt)
  );

  // The last tap's sum is rounded straight into the output register.
  assign rs           = round_sat(64'(acc_nxt), COEF_FRAC, CALC_BITS);
  assign unused_rs_hi = ^rs.val[31:CALC_BITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tap        <= '0;
      x0         <= '0;
      x1         <= '0;
      x2         <= '0;
      y1         <= '0;
      y2         <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      tap   <= '0;
      x0    <= '0;
      x1    <= '0;
      x2    <= '0;
      y1    <= '0;
      y2    <= '0;
    end else begin
      state <= state_n;
      tap   <= tap_n;
      if (accept) x0 <= bus.in_data;
      if (load_out) begin
        out_data_q <= rs.val[CALC_BITS-1:0];
        out_sat_q  <= rs.sat;
      end
      if (commit) begin
        x2 <= x1;
        x1 <= x0;
        y2 <= y1;
        y1 <= out_data_q;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_iir_biquad_seq.sv
// Scoreboard bench: default-coefficient and identity-coefficient instances
// driven with directed samples whose outputs were worked out by hand.
module tb_iir_biquad_seq;
  logic clk = 1'b0;
  logic reset, clr;
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;

  typedef struct { int d; bit s; } exp_t;
  exp_t q0[$], q1[$];

  iir_biquad_seq_if #(.CALC_BITS(16)) i0();
  iir_biquad_seq_if #(.CALC_BITS(16)) i1();

  iir_biquad_seq dut0 (.clk(clk), .reset(reset), .clr(clr), .bus(i0));
  iir_biquad_seq #(.B0(16384), .B1(0), .B2(0), .A1(0), .A2(0)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .bus(i1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hard_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitors: one pop per output handshake.
  always @(negedge clk) begin
    if (reset && i0.out_valid && i0.out_ready) begin
      if (q0.size() == 0) hard_fail("out0_unexpected");
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("out0_data", int'(i0.out_data), e.d);
        chk("out0_sat", int'(i0.out_sat), int'(e.s));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && i1.out_valid && i1.out_ready) begin
      if (q1.size() == 0) hard_fail("out1_unexpected");
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("out1_data", int'(i1.out_data), e.d);
        chk("out1_sat", int'(i1.out_sat), int'(e.s));
      end
    end
  end

  task automatic send(input int which, input int d, input int e, input bit s, input bit push);
    bit   got;
    exp_t x;
    got = 0;
    x.d = e;
    x.s = s;
    @(posedge clk); #1;
    if (which == 0) begin i0.in_valid = 1'b1; i0.in_data = 16'(d); end
    else            begin i1.in_valid = 1'b1; i1.in_data = 16'(d); end
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if ((which == 0) ? i0.in_ready : i1.in_ready) begin
        got = 1;
        if (push) begin
          if (which == 0) q0.push_back(x);
          else            q1.push_back(x);
        end
      end
    end
    @(posedge clk); #1;
    i0.in_valid = 1'b0;
    i1.in_valid = 1'b0;
    if (!got) hard_fail("send_timeout");
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) hard_fail("drain_timeout");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int acc_cyc[$], ov_cyc[$];
    int b2b_d[4]   = '{1000, 0, 0, 0};
    int b2b_e[4]   = '{250, 750, 938, 751};
    int idx;
    bit prev_ov;
    exp_t x;

    reset = 1'b0; clr = 1'b0;
    i0.in_valid = 1'b0; i0.in_data = '0; i0.out_ready = 1'b1;
    i1.in_valid = 1'b0; i1.in_data = '0; i1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(i0.out_valid), 0);
    chk("rst_out_data", int'(i0.out_data), 0);
    chk("rst_out_sat", int'(i0.out_sat), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(i0.in_ready), 1);

    // Impulse response with default coefficients
    send(0, 1000, 250, 0, 1);
    send(0, 0, 750, 0, 1);
    send(0, 0, 938, 0, 1);
    drain();

    // Identity coefficients
    pulse_reset();
    send(1, 123, 123, 0, 1);
    send(1, -456, -456, 0, 1);
    send(1, 32767, 32767, 0, 1);
    send(1, -32768, -32768, 0, 1);
    drain();

    // DC overload in both directions
    pulse_reset();
    send(0, 32767, 8192, 0, 1);
    send(0, 32767, 32767, 0, 1);
    send(0, 32767, 32767, 1, 1);
    drain();
    pulse_reset();
    send(0, -32768, -8192, 0, 1);
    send(0, -32768, -32768, 0, 1);
    send(0, -32768, -32768, 1, 1);
    drain();

    // Output stall: everything frozen, then the sequence resumes unchanged
    pulse_reset();
    i0.out_ready = 1'b0;
    send(0, 1000, 250, 0, 1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (i0.out_valid) seen = 1;
    end
    chk("stall_reached_out", seen, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(i0.out_valid), 1);
      chk("stall_out_data", int'(i0.out_data), 250);
      chk("stall_in_ready", int'(i0.in_ready), 0);
    end
    @(posedge clk); #1 i0.out_ready = 1'b1;
    send(0, 0, 750, 0, 1);
    send(0, 0, 938, 0, 1);
    drain();

    // clr in the second MAC cycle drops the sample and the history
    pulse_reset();
    send(0, 1000, 0, 0, 0);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    seen = 0;
    repeat (15) begin @(negedge clk); if (i0.out_valid) seen++; end
    chk("clr_no_out", seen, 0);
    send(0, 1000, 250, 0, 1);
    send(0, 0, 750, 0, 1);
    drain();

    // Same with reset in place of clr
    pulse_reset();
    send(0, 1000, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    seen = 0;
    repeat (15) begin @(negedge clk); if (i0.out_valid) seen++; end
    chk("rst_mid_no_out", seen, 0);
    send(0, 1000, 250, 0, 1);
    drain();

    // Back-to-back: accept cycle to first out_valid cycle, and accept spacing
    pulse_reset();
    idx = 0;
    prev_ov = 1'b0;
    @(posedge clk); #1;
    i0.in_valid = 1'b1;
    i0.in_data  = 16'(b2b_d[0]);
    repeat (40) begin
      @(negedge clk);
      if (i0.in_ready && i0.in_valid && idx < 4) begin
        acc_cyc.push_back(cyc);
        x.d = b2b_e[idx];
        x.s = 1'b0;
        q0.push_back(x);
        idx++;
      end
      if (i0.out_valid && !prev_ov) ov_cyc.push_back(cyc);
      prev_ov = i0.out_valid;
      @(posedge clk); #1;
      i0.in_valid = (idx < 4);
      if (idx < 4) i0.in_data = 16'(b2b_d[idx]);
    end
    i0.in_valid = 1'b0;
    drain();
    chk("b2b_accepts", acc_cyc.size(), 4);
    chk("b2b_outputs", ov_cyc.size(), 4);
    if (acc_cyc.size() == 4 && ov_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("b2b_latency", ov_cyc[k] - acc_cyc[k], 6);
      for (int k = 1; k < 4; k++) chk("b2b_period", acc_cyc[k] - acc_cyc[k-1], 7);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
